// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges the pipeline writeback stage and a buffered
// multi-cycle result stream onto the single register-file write port.
// The pipeline has priority. Multi-cycle results wait in a small FIFO and
// drain in free cycles. A head entry that waits STARVE_LIMIT cycles raises
// stall_o, which forces a drain on the next cycle.
module writeback_arbiter #(
  parameter int DATA_W       = 64,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pipe_we_i,
  input  logic [4:0]        pipe_rd_i,
  input  logic [DATA_W-1:0] pipe_data_i,
  input  logic              mc_valid_i,
  output logic              mc_ready_o,
  input  logic [4:0]        mc_rd_i,
  input  logic [DATA_W-1:0] mc_data_i,
  output logic              RegWrite_o,
  output logic [4:0]        RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o,
  output logic [31:0]       pending_o,
  output logic              stall_o,
  output logic              err_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [AGE_W-1:0] LIMIT_C = AGE_W'(STARVE_LIMIT);

  logic [4:0]            rd_mem   [FIFO_DEPTH];
  logic [DATA_W-1:0]     data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [AGE_W-1:0]      age_q;
  logic                  err_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic sel_pipe;
  logic err_set;
  logic pipe_wr;

  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  // Ready is gated by reset so the producer never sees a handshake during reset.
  assign mc_ready_o = rst_i & ~full;
  // Results aimed at x0 complete the handshake but are never stored.
  assign push       = mc_valid_i & mc_ready_o & (mc_rd_i != 5'd0);
  assign pipe_wr    = pipe_we_i & (pipe_rd_i != 5'd0);
  assign stall_o    = (age_q == LIMIT_C);
  assign err_o      = err_q;

  // Write-port selection: forced drain, then pipeline, then opportunistic drain.
  always_comb begin
    pop      = 1'b0;
    sel_pipe = 1'b0;
    err_set  = 1'b0;
    if (stall_o && !empty) begin
      pop     = 1'b1;
      err_set = pipe_we_i;
    end else if (pipe_wr) begin
      sel_pipe = 1'b1;
    end else if (!empty) begin
      pop = 1'b1;
    end
  end

  // Destination registers with a buffered write still outstanding.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (valid_q[i]) pending_o[rd_mem[i]] = 1'b1;
    end
  end

  // Entry storage; contents only matter while the slot's valid bit is set.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= mc_rd_i;
      data_mem[wr_ptr_q] <= mc_data_i;
    end
  end

  // FIFO pointers, occupancy count and per-slot valid bits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head-of-FIFO age; saturates at the limit, which is what raises stall_o.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      age_q <= '0;
    end else if (pop || empty) begin
      age_q <= '0;
    end else if (age_q != LIMIT_C) begin
      age_q <= age_q + 1'b1;
    end
  end

  // Registered register-file write port; address/data hold when idle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      RegWrite_o <= 1'b0;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
    end else if (pop) begin
      RegWrite_o <= 1'b1;
      RDaddr_o   <= rd_mem[rd_ptr_q];
      RDdata_o   <= data_mem[rd_ptr_q];
    end else if (sel_pipe) begin
      RegWrite_o <= 1'b1;
      RDaddr_o   <= pipe_rd_i;
      RDdata_o   <= pipe_data_i;
    end else begin
      RegWrite_o <= 1'b0;
    end
  end

  // Sticky flag: a forced drain collided with a pipeline write, which was dropped.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges the two register-file write sources of the 64-bit core into the single write port of the 32×64 register file. The pipeline writeback stage has priority. Results from the multi-cycle unit (mul/div, long loads) are buffered in a small FIFO under a valid/ready handshake and drained in free cycles. The block also reports which destination registers still have buffered writes, so the hazard unit can interlock on them, and it forces a drain when a buffered result starves.

## Interface
- DATA_W, 64, register data width
- FIFO_DEPTH, 2, multi-cycle result buffer entries (power of 2, ≥2)
- STARVE_LIMIT, 8, cycles a FIFO head may wait before a drain is forced (≥1)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- pipe_we_i  in  1  pipeline writeback valid; no backpressure
- pipe_rd_i  in  5  pipeline destination register
- pipe_data_i  in  DATA_W  pipeline write data
- mc_valid_i  in  1  multi-cycle result valid
- mc_ready_o  out  1  FIFO can accept
- mc_rd_i  in  5  multi-cycle destination register
- mc_data_i  in  DATA_W  multi-cycle result data
- RegWrite_o  out  1  register-file write enable (registered)
- RDaddr_o  out  5  register-file write address (registered)
- RDdata_o  out  DATA_W  register-file write data (registered)
- pending_o  out  32  bit r set while a FIFO entry targets rd r
- stall_o  out  1  forced-drain request to the pipeline
- err_o  out  1  sticky protocol-violation flag

## Operation
- **Reset (rst_i low, asynchronous):**
  - RegWrite_o, RDaddr_o, RDdata_o = 0.
  - FIFO empty; pending_o = 0.
  - Age counter = 0, so stall_o = 0; err_o = 0.
  - mc_ready_o is forced to 0 while rst_i is low.
  - Reset mid-operation discards all buffered entries.
- **Acceptance:**
  - mc_ready_o = !full. It depends on state only, never on mc_valid_i.
  - An entry is accepted when mc_valid_i && mc_ready_o.
  - An accepted entry with mc_rd_i = 0 is consumed and discarded: it is not enqueued and never written.
  - When full, no push occurs even if a pop happens the same cycle.
- **Output selection, evaluated each cycle:**
  1. If stall_o = 1 and the FIFO is non-empty: pop the head and drive it. If pipe_we_i = 1 in the same cycle, set err_o and drop the pipeline write.
  2. Else if pipe_we_i && pipe_rd_i != 0: drive the pipeline write.
  3. Else if the FIFO is non-empty: pop the head and drive it.
  4. Else RegWrite_o = 0. RDaddr_o/RDdata_o hold their previous values.
- A pipeline write to x0 is treated as no write, so it falls through to choice 3.
- **Age counter:**
  - Resets to 0 on any pop and whenever the FIFO is empty.
  - Increments each cycle the FIFO is non-empty and the head is not popped; saturates at STARVE_LIMIT.
  - stall_o = (age == STARVE_LIMIT).
- **Ordering:** the block never reorders or squashes.
  - The hazard unit must stall any instruction whose rd or rs hits pending_o.
  - A pipeline write and a FIFO entry to the same rd in flight together is a system-level error and is not detected here.
- **pending_o:** OR of one-hot decodes of the rd of every valid FIFO entry.
  - An entry's bit clears in the cycle after it is popped, i.e. while it sits in the output register.
  - Its register-file write then completes at the following edge.
- **err_o:** cleared only by reset.

## Timing
- **Pipeline path:** pipe_we_i sampled at edge N → RegWrite_o high in cycle N..N+1. The register file is written at edge N+1.
- **Multi-cycle path:**
  - Accepted at edge N → entry visible in FIFO and pending_o after N.
  - Earliest RegWrite_o is after edge N+1. There is no bypass around the FIFO.
- **Throughput:**
  - One register-file write per cycle.
  - One accept per cycle while not full.
  - mc_ready_o rises the cycle after the pop that un-fills the FIFO.
- **stall_o:**
  - Registered, from the age counter.
  - Asserted in the cycle the forced pop occurs; deasserted after that pop.
- **Pointer wrap:** log2(FIFO_DEPTH)-bit read/write pointers plus a count, wrapping modulo FIFO_DEPTH.

## Test plan
- **Reset defaults:** drive rst_i low mid-stream with 2 entries buffered → immediately RegWrite_o=0, pending_o=0, mc_ready_o=0, err_o=0. After release: mc_ready_o=1 and no stale writes.
- **Pipeline priority:**
  - Stimulus: pipe write rd=5, data=0x1111 every cycle for 3 cycles; mc result rd=7, data=0xAAAA accepted in cycle 0.
  - Required: RegWrite_o carries rd=5 three times, then rd=7/0xAAAA. pending_o[7]=1 until the pop.
- **Full/backpressure:**
  - Stimulus: 3 back-to-back mc results (rd 1,2,3) with pipe_we_i continuously high, rd=9.
  - Required: mc_ready_o=0 after 2 accepts; third result held until a slot frees; order 1,2,3 preserved.
- **Starvation:**
  - Stimulus: STARVE_LIMIT=4, one buffered entry, pipe_we_i high continuously.
  - Required: stall_o=1 after 4 waiting cycles. If the pipeline deasserts pipe_we_i, the entry is written and err_o stays 0. If pipe_we_i stays high, the entry is still written and err_o=1.
- **x0 discard:** pipe rd=0 and mc rd=0 writes → RegWrite_o never asserted for address 0. The mc handshake completes with no pending bit set.
- **Wrap-around:** 10 alternating accepts/pops with FIFO_DEPTH=2 → every value is written exactly once, in order, with distinct data 0x1..0xA.
